// File: rtl/codec_pwrseq_clkgen.sv
// Codec power-down sequencing and serial-audio clock generation from the 256fs clock.
// The codec is held in power-down, then allowed to wake, then given BICK/LRCK plus a frame strobe.
module codec_pwrseq_clkgen #(
    parameter int PDN_LOW_CYCLES = 4096,
    parameter int WAKE_CYCLES    = 16384
) (
    input  logic       clk_256fs,
    input  logic       rst_n,
    input  logic       restart,
    output logic       codec_pdn_n,
    output logic       bick,
    output logic       lrck,
    output logic       frame_strobe,
    output logic       ready,
    output logic [3:0] restart_count
);

    typedef enum logic [1:0] {
        PDN_HOLD = 2'd0,
        WAKE     = 2'd1,
        RUN      = 2'd2
    } state_t;

    localparam logic [15:0] PDN_LAST  = 16'(PDN_LOW_CYCLES - 1);
    localparam logic [15:0] WAKE_LAST = 16'(WAKE_CYCLES - 1);

    state_t      state;
    logic [15:0] timer;
    logic [7:0]  phase;
    logic        restart_prev;
    logic [7:0]  phase_inc;

    assign phase_inc = phase + 8'd1;

    always_ff @(posedge clk_256fs) begin
        if (!rst_n) begin
            state         <= PDN_HOLD;
            timer         <= 16'd0;
            phase         <= 8'd0;
            restart_prev  <= 1'b0;
            codec_pdn_n   <= 1'b0;
            bick          <= 1'b0;
            lrck          <= 1'b0;
            frame_strobe  <= 1'b0;
            ready         <= 1'b0;
            restart_count <= 4'd0;
        end else begin
            restart_prev <= restart;
            if (restart) begin
                // A held request keeps the block parked here but is counted only once.
                if (!restart_prev && restart_count != 4'd15)
                    restart_count <= restart_count + 4'd1;
                state        <= PDN_HOLD;
                timer        <= 16'd0;
                phase        <= 8'd0;
                codec_pdn_n  <= 1'b0;
                bick         <= 1'b0;
                lrck         <= 1'b0;
                frame_strobe <= 1'b0;
                ready        <= 1'b0;
            end else begin
                case (state)
                    PDN_HOLD: begin
                        phase        <= 8'd0;
                        bick         <= 1'b0;
                        lrck         <= 1'b0;
                        frame_strobe <= 1'b0;
                        ready        <= 1'b0;
                        if (timer == PDN_LAST) begin
                            state       <= WAKE;
                            timer       <= 16'd0;
                            codec_pdn_n <= 1'b1;
                        end else begin
                            timer       <= timer + 16'd1;
                            codec_pdn_n <= 1'b0;
                        end
                    end
                    WAKE: begin
                        phase       <= 8'd0;
                        bick        <= 1'b0;
                        lrck        <= 1'b0;
                        codec_pdn_n <= 1'b1;
                        if (timer == WAKE_LAST) begin
                            // First RUN cycle sits at phase 0, so it carries the frame strobe.
                            state        <= RUN;
                            timer        <= 16'd0;
                            frame_strobe <= 1'b1;
                            ready        <= 1'b1;
                        end else begin
                            timer        <= timer + 16'd1;
                            frame_strobe <= 1'b0;
                            ready        <= 1'b0;
                        end
                    end
                    RUN: begin
                        timer        <= 16'd0;
                        phase        <= phase_inc;
                        bick         <= phase_inc[1];
                        lrck         <= phase_inc[7];
                        frame_strobe <= (phase_inc == 8'd0);
                        codec_pdn_n  <= 1'b1;
                        ready        <= 1'b1;
                    end
                    default: begin
                        state        <= PDN_HOLD;
                        timer        <= 16'd0;
                        phase        <= 8'd0;
                        codec_pdn_n  <= 1'b0;
                        bick         <= 1'b0;
                        lrck         <= 1'b0;
                        frame_strobe <= 1'b0;
                        ready        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_codec_pwrseq_clkgen.sv
// Directed bench for codec_pwrseq_clkgen with short hold/wake counts (8 and 16 cycles).
module tb_codec_pwrseq_clkgen;

    logic       clk_256fs = 1'b0;
    logic       rst_n     = 1'b0;
    logic       restart   = 1'b0;
    logic       codec_pdn_n, bick, lrck, frame_strobe, ready;
    logic [3:0] restart_count;

    codec_pwrseq_clkgen #(
        .PDN_LOW_CYCLES(8),
        .WAKE_CYCLES   (16)
    ) dut (
        .clk_256fs    (clk_256fs),
        .rst_n        (rst_n),
        .restart      (restart),
        .codec_pdn_n  (codec_pdn_n),
        .bick         (bick),
        .lrck         (lrck),
        .frame_strobe (frame_strobe),
        .ready        (ready),
        .restart_count(restart_count)
    );

    always #5 clk_256fs = ~clk_256fs;

    typedef struct {
        int         cyc;
        logic       pdn;
        logic       bick;
        logic       lrck;
        logic       fs;
        logic       rdy;
        logic [3:0] cnt;
    } vec_t;

    int   nchk  = 0;
    int   npass = 0;
    int   cyc   = 0;
    vec_t tab[$];

    function automatic vec_t mk(int c, logic p, logic b, logic l, logic f, logic r, int n);
        vec_t v;
        v.cyc = c; v.pdn = p; v.bick = b; v.lrck = l; v.fs = f; v.rdy = r; v.cnt = 4'(n);
        return v;
    endfunction

    // Cycle k is the interval after k edges have sampled rst_n high; sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_256fs);
        #1;
        cyc++;
    endtask

    task automatic run_to(int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        restart = 1'b0;
        repeat (3) @(posedge clk_256fs);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic check_outs(string name, vec_t e);
        logic [8:0] got, exp;
        got = {codec_pdn_n, bick, lrck, frame_strobe, ready, restart_count};
        exp = {e.pdn, e.bick, e.lrck, e.fs, e.rdy, e.cnt};
        nchk++;
        if (got !== exp)
            $display("FAIL %s cyc=%0d got pdn,bick,lrck,fs,rdy,cnt=%b required %b", name, cyc, got, exp);
        else begin
            npass++;
            $display("ok   %s cyc=%0d outs=%b", name, cyc, got);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        nchk++;
        if (got != exp)
            $display("FAIL %s got %0d required %0d", name, got, exp);
        else begin
            npass++;
            $display("ok   %s = %0d", name, got);
        end
    endtask

    initial begin
        int idx;
        int strobes;
        int strobe_err;

        // Power-up timeline and steady-state clock shape.
        tab.push_back(mk(0,    0, 0, 0, 0, 0, 0));
        tab.push_back(mk(7,    0, 0, 0, 0, 0, 0));
        tab.push_back(mk(8,    1, 0, 0, 0, 0, 0));
        tab.push_back(mk(23,   1, 0, 0, 0, 0, 0));
        tab.push_back(mk(24,   1, 0, 0, 1, 1, 0));
        tab.push_back(mk(25,   1, 0, 0, 0, 1, 0));
        tab.push_back(mk(26,   1, 1, 0, 0, 1, 0));
        tab.push_back(mk(27,   1, 1, 0, 0, 1, 0));
        tab.push_back(mk(28,   1, 0, 0, 0, 1, 0));
        tab.push_back(mk(151,  1, 1, 0, 0, 1, 0));
        tab.push_back(mk(152,  1, 0, 1, 0, 1, 0));
        tab.push_back(mk(279,  1, 1, 1, 0, 1, 0));
        tab.push_back(mk(280,  1, 0, 0, 1, 1, 0));
        tab.push_back(mk(281,  1, 0, 0, 0, 1, 0));
        tab.push_back(mk(536,  1, 0, 0, 1, 1, 0));
        tab.push_back(mk(792,  1, 0, 0, 1, 1, 0));
        tab.push_back(mk(793,  1, 0, 0, 0, 1, 0));
        tab.push_back(mk(1047, 1, 1, 1, 0, 1, 0));

        do_reset();
        idx        = 0;
        strobes    = 0;
        strobe_err = 0;
        while (cyc <= 1047) begin
            if (frame_strobe === 1'b1) begin
                strobes++;
                if (((cyc - 24) % 256) != 0 || cyc < 24) strobe_err++;
            end
            if (idx < tab.size() && tab[idx].cyc == cyc) begin
                check_outs("timeline", tab[idx]);
                idx++;
            end
            step();
        end
        check_int("strobe_count", strobes, 4);
        check_int("strobe_misplaced", strobe_err, 0);

        // One-cycle restart in RUN.
        do_reset();
        run_to(100);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_outs("rst_run_101", mk(0, 0, 0, 0, 0, 0, 1));
        run_to(108); check_outs("rst_run_108", mk(0, 0, 0, 0, 0, 0, 1));
        run_to(109); check_outs("rst_run_109", mk(0, 1, 0, 0, 0, 0, 1));
        run_to(124); check_outs("rst_run_124", mk(0, 1, 0, 0, 0, 0, 1));
        run_to(125); check_outs("rst_run_125", mk(0, 1, 0, 0, 1, 1, 1));

        // Restart on the hold terminal count wins and re-arms a full hold.
        do_reset();
        run_to(7);
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_outs("rst_tc_8", mk(0, 0, 0, 0, 0, 0, 1));
        run_to(15); check_outs("rst_tc_15", mk(0, 0, 0, 0, 0, 0, 1));
        run_to(16); check_outs("rst_tc_16", mk(0, 1, 0, 0, 0, 0, 1));

        // Restart in PDN_HOLD at cycle 5, held for three cycles: counted once.
        do_reset();
        run_to(5);
        restart = 1'b1;
        run_to(8);
        restart = 1'b0;
        check_outs("hold3_8", mk(0, 0, 0, 0, 0, 0, 1));
        run_to(15); check_outs("hold3_15", mk(0, 0, 0, 0, 0, 0, 1));
        run_to(16); check_outs("hold3_16", mk(0, 1, 0, 0, 0, 0, 1));
        run_to(32); check_outs("hold3_32", mk(0, 1, 0, 0, 1, 1, 1));

        // Reset together with restart during RUN: reset wins, count cleared.
        run_to(40);
        rst_n   = 1'b0;
        restart = 1'b1;
        step();
        check_outs("rst_and_restart", mk(0, 0, 0, 0, 0, 0, 0));
        rst_n   = 1'b1;
        restart = 1'b0;
        cyc     = 0;
        step();
        check_outs("after_rst_1", mk(0, 0, 0, 0, 0, 0, 0));

        // Twenty separated restart pulses saturate the counter at 15.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            restart = 1'b1;
            step();
            restart = 1'b0;
            step();
            if (i == 1 || i == 14 || i == 15 || i == 16 || i == 20)
                check_int($sformatf("sat_count_%0d", i), int'(restart_count), (i > 15) ? 15 : i);
        end
        begin
            int r;
            r = cyc - 2;
            run_to(r + 25);
            check_outs("sat_recover", mk(0, 1, 0, 0, 1, 1, 15));
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
